// File: rtl/hue_arbiter_if.sv
// Handshake and pipeline bus shared between the hue arbiter and its environment.
// slave: the arbiter's view; master: the requesters, the hue pipeline and the result consumers.
interface hue_arbiter_if;
   logic [15:0] i_req0_data;
   logic        i_req0_valid;
   logic        o_req0_ready;
   logic [15:0] i_req1_data;
   logic        i_req1_valid;
   logic        o_req1_ready;
   logic [15:0] o_pipe_data;
   logic        o_pipe_valid;
   logic [15:0] i_pipe_data;
   logic        i_pipe_valid;
   logic [15:0] o_hue0_data;
   logic        o_hue0_valid;
   logic [15:0] o_hue1_data;
   logic        o_hue1_valid;
   logic        o_err;

   modport slave (
      input  i_req0_data, i_req0_valid, i_req1_data, i_req1_valid,
      input  i_pipe_data, i_pipe_valid,
      output o_req0_ready, o_req1_ready, o_pipe_data, o_pipe_valid,
      output o_hue0_data, o_hue0_valid, o_hue1_data, o_hue1_valid, o_err
   );

   modport master (
      output i_req0_data, i_req0_valid, i_req1_data, i_req1_valid,
      output i_pipe_data, i_pipe_valid,
      input  o_req0_ready, o_req1_ready, o_pipe_data, o_pipe_valid,
      input  o_hue0_data, o_hue0_valid, o_hue1_data, o_hue1_valid, o_err
   );
endinterface

// File: rtl/hue_arbiter.sv
// Shares one fixed-latency hue pipeline between two requesters and steers results back by tag.
// Define HUE_ARB_STRICT_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module hue_arbiter #(
   parameter int unsigned PIPE_LAT = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   hue_arbiter_if.slave  bus
);
   localparam int unsigned TAIL = PIPE_LAT - 1;

   logic                grant0;
   logic                grant1;
   logic                pipe_valid;
   logic [15:0]         pipe_data;
   logic                pipe_owner;
   logic [PIPE_LAT-1:0] tag_v;
   logic [PIPE_LAT-1:0] tag_o;
   logic                tail_valid;
   logic                tail_owner;
   logic                ret_hit;
   logic                hue0_valid;
   logic [15:0]         hue0_data;
   logic                hue1_valid;
   logic [15:0]         hue1_data;
   logic                err;

`ifdef HUE_ARB_STRICT_PRIO_EN
   always_comb begin
      grant0 = bus.i_req0_valid;
      grant1 = bus.i_req1_valid & ~bus.i_req0_valid;
   end
`else
   // 1 means requester 1 holds the most recent grant, so requester 0 wins a tie
   logic last_grant;

   always_comb begin
      grant0 = bus.i_req0_valid & (~bus.i_req1_valid | last_grant);
      grant1 = bus.i_req1_valid & (~bus.i_req0_valid | ~last_grant);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant <= 1'b1;
      end else if (grant0 | grant1) begin
         last_grant <= grant1;
      end
   end
`endif

   assign tail_valid = tag_v[TAIL];
   assign tail_owner = tag_o[TAIL];
   assign ret_hit    = tail_valid & bus.i_pipe_valid;

   // Issue, tag tracking and result steering
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pipe_valid <= 1'b0;
         pipe_data  <= 16'h0000;
         pipe_owner <= 1'b0;
         tag_v      <= '0;
         tag_o      <= '0;
         hue0_valid <= 1'b0;
         hue0_data  <= 16'h0000;
         hue1_valid <= 1'b0;
         hue1_data  <= 16'h0000;
         err        <= 1'b0;
      end else begin
         pipe_valid <= grant0 | grant1;
         if (grant0 | grant1) begin
            pipe_data  <= grant1 ? bus.i_req1_data : bus.i_req0_data;
            pipe_owner <= grant1;
         end
         tag_v <= (tag_v << 1) | PIPE_LAT'(pipe_valid);
         tag_o <= (tag_o << 1) | PIPE_LAT'(pipe_owner);

         hue0_valid <= ret_hit & ~tail_owner;
         hue1_valid <= ret_hit & tail_owner;
         if (ret_hit & ~tail_owner) begin
            hue0_data <= bus.i_pipe_data;
         end
         if (ret_hit & tail_owner) begin
            hue1_data <= bus.i_pipe_data;
         end
         // A result without a matching tag (or a missing result) is dropped and flagged
         if (tail_valid != bus.i_pipe_valid) begin
            err <= 1'b1;
         end
      end
   end

   assign bus.o_req0_ready = grant0 & ~i_rst;
   assign bus.o_req1_ready = grant1 & ~i_rst;
   assign bus.o_pipe_valid = pipe_valid;
   assign bus.o_pipe_data  = pipe_data;
   assign bus.o_hue0_valid = hue0_valid;
   assign bus.o_hue0_data  = hue0_data;
   assign bus.o_hue1_valid = hue1_valid;
   assign bus.o_hue1_data  = hue1_data;
   assign bus.o_err        = err;
endmodule

// File: tb/tb_hue_arbiter.sv
// Self-checking bench for hue_arbiter: grant table, behavioural hue pipeline and per-requester scoreboards.
module tb_hue_arbiter;
   localparam int unsigned PIPE_LAT = 3;
   localparam int          HUE_LAT  = PIPE_LAT + 2;

   logic clk;
   logic i_rst;
   logic force_pv;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   n_hue0;
   int   n_hue1;

   hue_arbiter_if bus ();

   hue_arbiter #(.PIPE_LAT(PIPE_LAT)) dut (
      .i_clk (clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [15:0] hue;
      int          cyc;
   } exp_t;

   typedef struct {
      logic v0;
      logic v1;
      logic r0;
      logic r1;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Integer hue of an RGB565 pixel, 0..359
   function automatic logic [15:0] hue_of(input logic [15:0] px);
      int r, g, b, mx, mn, d, h;
      r = int'(px[15:11]) * 2;
      g = int'(px[10:5]);
      b = int'(px[4:0]) * 2;
      mx = (r > g) ? r : g;
      mx = (b > mx) ? b : mx;
      mn = (r < g) ? r : g;
      mn = (b < mn) ? b : mn;
      d  = mx - mn;
      if (d == 0)       h = 0;
      else if (mx == r) h = (60 * (g - b)) / d;
      else if (mx == g) h = 120 + (60 * (b - r)) / d;
      else              h = 240 + (60 * (r - g)) / d;
      if (h < 0) h = h + 360;
      return 16'(h);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   // Behavioural hue pipeline with the same reset as the arbiter
   logic [15:0] pm_d [PIPE_LAT];
   logic        pm_v [PIPE_LAT];

   always @(posedge clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            pm_v[i] <= 1'b0;
            pm_d[i] <= 16'h0000;
         end
      end else begin
         pm_v[0] <= bus.o_pipe_valid;
         pm_d[0] <= hue_of(bus.o_pipe_data);
         for (int i = 1; i < int'(PIPE_LAT); i++) begin
            pm_v[i] <= pm_v[i-1];
            pm_d[i] <= pm_d[i-1];
         end
      end
   end

   assign bus.i_pipe_valid = pm_v[PIPE_LAT-1] | force_pv;
   assign bus.i_pipe_data  = pm_d[PIPE_LAT-1];

   // Scoreboard: push on transfer, pop and compare on result strobe
   always @(negedge clk) begin
      exp_t e;
      if (i_rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (bus.o_req0_ready && bus.o_req1_ready) chk("grant_onehot", 32'(bus.o_req1_ready), 32'd0);
         if (bus.o_hue0_valid) begin
            n_hue0++;
            if (q0.size() == 0) chk("hue0_spurious", 32'(bus.o_hue0_valid), 32'd0);
            else begin
               e = q0.pop_front();
               chk("hue0_data", 32'(bus.o_hue0_data), 32'(e.hue));
               chk("hue0_latency", 32'(cyc - e.cyc), 32'(HUE_LAT));
            end
         end
         if (bus.o_hue1_valid) begin
            n_hue1++;
            if (q1.size() == 0) chk("hue1_spurious", 32'(bus.o_hue1_valid), 32'd0);
            else begin
               e = q1.pop_front();
               chk("hue1_data", 32'(bus.o_hue1_data), 32'(e.hue));
               chk("hue1_latency", 32'(cyc - e.cyc), 32'(HUE_LAT));
            end
         end
         if (bus.i_req0_valid && bus.o_req0_ready) q0.push_back('{hue_of(bus.i_req0_data), cyc});
         if (bus.i_req1_valid && bus.o_req1_ready) q1.push_back('{hue_of(bus.i_req1_data), cyc});
      end
   end

   task automatic drain();
      for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
      #1;
      chk("drain_q0_empty", 32'(q0.size()), 32'd0);
      chk("drain_q1_empty", 32'(q1.size()), 32'd0);
   endtask

   vec_t        tbl[14];
   logic [15:0] d0, d1;
   logic        x0, x1, e0, e1;
   int          h0, h1;

   initial begin
      cyc = 0; n_checks = 0; n_pass = 0; n_hue0 = 0; n_hue1 = 0;
      force_pv = 1'b0;
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0};

      // Reset with both requesters asserting valid
      i_rst = 1'b1;
      d0 = 16'($urandom); d1 = 16'($urandom);
      bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
      bus.i_req0_data = d0;    bus.i_req1_data = d1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", 32'(bus.o_req0_ready), 32'd0);
      chk("rst_ready1", 32'(bus.o_req1_ready), 32'd0);
      chk("rst_pipe_valid", 32'(bus.o_pipe_valid), 32'd0);
      chk("rst_err", 32'(bus.o_err), 32'd0);
      chk("rst_hue_valid", 32'({bus.o_hue0_valid, bus.o_hue1_valid}), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;

      // Grant table, starting on the first cycle out of reset
      x0 = 1'b0; x1 = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (x0) d0 = 16'($urandom);
         if (x1) d1 = 16'($urandom);
         bus.i_req0_valid = tbl[i].v0; bus.i_req1_valid = tbl[i].v1;
         bus.i_req0_data  = d0;        bus.i_req1_data  = d1;
`ifdef HUE_ARB_STRICT_PRIO_EN
         e0 = tbl[i].v0;
         e1 = tbl[i].v1 & ~tbl[i].v0;
`else
         e0 = tbl[i].r0;
         e1 = tbl[i].r1;
`endif
         @(negedge clk);
         chk($sformatf("tbl%0d_ready0", i), 32'(bus.o_req0_ready), 32'(e0));
         chk($sformatf("tbl%0d_ready1", i), 32'(bus.o_req1_ready), 32'(e1));
         x0 = bus.i_req0_valid & bus.o_req0_ready;
         x1 = bus.i_req1_valid & bus.o_req1_ready;
         @(posedge clk); #1;
      end
      bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
      drain();

      // Single red pixel from requester 0
      h1 = n_hue1;
      bus.i_req0_valid = 1'b1; bus.i_req0_data = 16'hF800;
      @(negedge clk);
      chk("red_ready0", 32'(bus.o_req0_ready), 32'd1);
      @(posedge clk); #1;
      bus.i_req0_valid = 1'b0;
      @(negedge clk);
      chk("red_pipe_valid", 32'(bus.o_pipe_valid), 32'd1);
      chk("red_pipe_data", 32'(bus.o_pipe_data), 32'hF800);
      @(negedge clk);
      chk("idle_pipe_valid", 32'(bus.o_pipe_valid), 32'd0);
      chk("idle_pipe_data_hold", 32'(bus.o_pipe_data), 32'hF800);
      drain();
      chk("red_no_hue1", 32'(n_hue1 - h1), 32'd0);

      // Pipeline valid with no tag in flight
      @(posedge clk); #1;
      h0 = n_hue0; h1 = n_hue1;
      force_pv = 1'b1;
      @(negedge clk);
      chk("err_before", 32'(bus.o_err), 32'd0);
      @(posedge clk); #1;
      force_pv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("err_sticky%0d", i), 32'(bus.o_err), 32'd1);
      end
      chk("err_no_strobe", 32'((n_hue0 - h0) + (n_hue1 - h1)), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(bus.o_err), 32'd0);

      // Reset with three pixels in flight
      @(posedge clk); #1;
      bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_req0_data = 16'($urandom); bus.i_req1_data = 16'($urandom);
         @(posedge clk); #1;
      end
      bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      h0 = n_hue0; h1 = n_hue1;
      repeat (10) @(posedge clk);
      #1;
      chk("flush_no_hue0", 32'(n_hue0 - h0), 32'd0);
      chk("flush_no_hue1", 32'(n_hue1 - h1), 32'd0);
      chk("flush_no_err", 32'(bus.o_err), 32'd0);
      bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
      @(negedge clk);
      chk("restart_ready0", 32'(bus.o_req0_ready), 32'd1);
      chk("restart_ready1", 32'(bus.o_req1_ready), 32'd0);
      @(posedge clk); #1;
      bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
      drain();
      chk("final_err", 32'(bus.o_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
